// File: rtl/inta_sequencer_pkg.sv
// Shared types and defaults for the interrupt-acknowledge sequencer.
// Holds the FSM state enum, the vector width and the default timing constants.
package inta_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK1  = 3'd1,
        GAP   = 3'd2,
        ACK2  = 3'd3,
        HOLD  = 3'd4,
        DRAIN = 3'd5
    } inta_state_e;

    localparam int VEC_W               = 8;
    localparam int DEF_INTA_LOW_CYCLES = 2;
    localparam int DEF_INTA_GAP_CYCLES = 1;
    localparam int DEF_TIMEOUT_CYCLES  = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/inta_sequencer_sync_2ff.sv
// Generic two-flop level synchroniser, clears to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge initiator: two timed INTA pulses, vector capture, valid/ack to core.
// Build option INTA_SEQ_TIMEOUT_EN adds a stuck-int_req timeout in DRAIN.
//
// state | meaning
// IDLE  | waiting for synchronised int_req with enable
// ACK1  | first INTA pulse (inta low)
// GAP   | inta high between pulses
// ACK2  | second INTA pulse, vector sampled on its final edge
// HOLD  | vector valid, waiting for core ack
// DRAIN | waiting for int_req to drop (or timeout)
module inta_sequencer
    import inta_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = DEF_INTA_LOW_CYCLES,
    parameter int INTA_GAP_CYCLES = DEF_INTA_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             int_req,
    input  logic             enable,
    input  logic [VEC_W-1:0] data_in,
    output logic             inta_n,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    input  logic             vector_ack,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_MAX = max3(INTA_LOW_CYCLES, INTA_GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);

    inta_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;
    logic             int_req_s;

    logic             inta_n_q, inta_n_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    sync_2ff #(.WIDTH(1)) u_sync_int (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (int_req),
        .q_o   (int_req_s)
    );

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The shared down-counter is loaded on every timed-state entry and expires at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (int_req_s && enable) begin
                    state_d = ACK1;
                    cnt_d   = LOW_LOAD;
                end
            end
            ACK1: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = ACK2;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK2: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (vector_ack) begin
                    state_d = DRAIN;
`ifdef INTA_SEQ_TIMEOUT_EN
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            DRAIN: begin
                if (!int_req_s) begin
                    state_d = IDLE;
`ifdef INTA_SEQ_TIMEOUT_EN
                end else if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        inta_n_d = !((state_d == ACK1) || (state_d == ACK2));
        busy_d   = (state_d != IDLE);
        vector_d = vector_q;
        valid_d  = valid_q;
        if ((state_q == ACK2) && (state_d == HOLD)) begin
            vector_d = data_in;
            valid_d  = 1'b1;
        end else if ((state_q == HOLD) && vector_ack) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_n_q <= 1'b1;
            vector_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            inta_n_q <= inta_n_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

`ifdef INTA_SEQ_TIMEOUT_EN
    logic timeout_q, timeout_d;

    assign timeout_d = (state_q == DRAIN) && int_req_s && cnt_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign inta_n       = inta_n_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: per-sequence expectations are derived from edge arithmetic
// (trigger edge + synchroniser delay + pulse widths) and checked by a decoupled monitor.
module tb_inta_sequencer;

    localparam int L  = 2;   // INTA low clocks
    localparam int G  = 1;   // gap clocks
    localparam int TO = 16;  // timeout clocks

    typedef struct packed {
        logic [7:0] vec;
        int         cap;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       int_req;
    logic       enable;
    logic [7:0] data_in;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ack;
    logic       busy;
    logic       timeout_err;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    cap_edge = -1;
    logic [7:0] cur_vec = 8'h00;
    bit    force_ff = 1'b0;

    item_t sb_q[$];
    bit    low_e[int];
    bit    valid_e[int];
    bit    to_e[int];

    logic [7:0] cur_exp_vec = 8'h00;
    logic       prev_v = 1'b0;

    inta_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_req      (int_req),
        .enable       (enable),
        .data_in      (data_in),
        .inta_n       (inta_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ack   (vector_ack),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Data bus: the vector only during the cycle before the capture edge, junk elsewhere.
    always @(posedge clk) begin
        #1;
        if (cap_edge > 0 && cyc == cap_edge - 1) data_in = cur_vec;
        else if (force_ff) data_in = 8'hFF;
        else data_in = 8'($urandom);
    end

    // Monitor: pops the scoreboard when the DUT raises vector_valid, checks per-cycle outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            cur_exp_vec = 8'h00;
            prev_v = 1'b0;
        end else begin
            if (vector_valid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL valid_rise at edge %0d: got valid with vector %0h, expected no pending vector", cyc, vector);
                end else begin
                    item_t it;
                    it = sb_q.pop_front();
                    chk("vec_data", 32'(vector), 32'(it.vec));
                    chk("vec_latency", cyc, it.cap);
                    cur_exp_vec = it.vec;
                end
            end
            prev_v = vector_valid;
            chk("inta_n", 32'(inta_n), low_e.exists(cyc) ? 0 : 1);
            chk("vector_valid", 32'(vector_valid), valid_e.exists(cyc) ? 1 : 0);
            chk("vector_stable", 32'(vector), 32'(cur_exp_vec));
            chk("timeout_err", 32'(timeout_err), to_e.exists(cyc) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic schedule(input int s, input logic [7:0] v, output int c);
        item_t it;
        for (int i = 0; i < L; i++) begin
            low_e[s + i]         = 1'b1;
            low_e[s + L + G + i] = 1'b1;
        end
        c        = s + 2 * L + G;
        cap_edge = c;
        cur_vec  = v;
        it.vec   = v;
        it.cap   = c;
        sb_q.push_back(it);
    endtask

    // One acknowledge sequence starting (inta low) after edge s; returns the ack edge.
    task automatic seq_body(input int s, input logic [7:0] v, input bit early, input int ack_d,
                            input int drop_lo, input bit stuck, output int a);
        int c, drop, en_drop, k;
        schedule(s, v, c);
        a = early ? c + 1 : c + 1 + ack_d;
        for (int i = c; i < a; i++) valid_e[i] = 1'b1;
        drop    = stuck ? -1 : int'($urandom_range(a - 1, drop_lo));
        en_drop = ($urandom_range(1, 0) == 1) ? int'($urandom_range(a - 1, s)) : -1;
        while (cyc < a) begin
            tick();
            k = cyc;
            if (k == drop) int_req = 1'b0;
            if (k == en_drop) enable = 1'b0;
            if (early && k == s) vector_ack = 1'b1;
            if (!early && k == a - 1) vector_ack = 1'b1;
            if (k == a) vector_ack = 1'b0;
            if (k == s) chk("busy_seq", 32'(busy), 1);
        end
        enable = 1'b1;
    endtask

    task automatic run_normal(input logic [7:0] v, input bit early, input int ack_d);
        int e, a;
        enable  = 1'b1;
        e       = cyc;
        int_req = 1'b1;
        seq_body(e + 3, v, early, ack_d, e + 1, 1'b0, a);
        repeat (5) tick();
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic run_gated(input logic [7:0] v, input int ack_d);
        int e, a;
        enable  = 1'b0;
        int_req = 1'b1;
        repeat (20) begin
            tick();
            chk("gated_busy", 32'(busy), 0);
        end
        e      = cyc;
        enable = 1'b1;
        seq_body(e + 1, v, 1'b0, ack_d, e + 1, 1'b0, a);
        repeat (5) tick();
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int e, c, a, a2, s2;
        rst_n      = 1'b0;
        int_req    = 1'b0;
        enable     = 1'b0;
        vector_ack = 1'b0;
        data_in    = 8'h00;
        repeat (3) tick();
        chk("rst_inta_n", 32'(inta_n), 1);
        chk("rst_vector", 32'(vector), 0);
        chk("rst_valid", 32'(vector_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        run_normal(8'h48, 1'b0, 2);
        run_gated(8'($urandom), 3);
        run_normal(8'($urandom), 1'b0, 10);
        run_normal(8'($urandom), 1'b1, 0);
        force_ff = 1'b1;
        run_normal(8'h21, 1'b0, 4);
        force_ff = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(3, 0) == 0) run_gated(8'($urandom), int'($urandom_range(10, 0)));
            else run_normal(8'($urandom), ($urandom_range(3, 0) == 0), int'($urandom_range(10, 0)));
        end

        // Reset in the middle of ACK2 discards the partial vector.
        enable  = 1'b1;
        e       = cyc;
        int_req = 1'b1;
        schedule(e + 3, 8'h5A, c);
        while (cyc < e + 3 + L + G) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_inta_n", 32'(inta_n), 1);
        chk("async_valid", 32'(vector_valid), 0);
        chk("async_vector", 32'(vector), 0);
        chk("async_busy", 32'(busy), 0);
        for (int k = cyc; k < cyc + 20; k++) low_e.delete(k);
        cap_edge = -1;
        int_req  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", 32'(busy), 0);

        run_normal(8'hC3, 1'b0, 1);

        // int_req stuck high after the handshake.
        enable  = 1'b1;
        e       = cyc;
        int_req = 1'b1;
        seq_body(e + 3, 8'h77, 1'b0, 3, e + 1, 1'b1, a);
`ifdef INTA_SEQ_TIMEOUT_EN
        to_e[a + TO] = 1'b1;
        s2 = a + TO + 1;
        seq_body(s2, 8'h99, 1'b0, 2, s2, 1'b0, a2);
        repeat (5) tick();
        chk("busy_after_timeout", 32'(busy), 0);
`else
        s2 = a;
        a2 = a;
        repeat (40) begin
            tick();
            chk("drain_busy", 32'(busy), 1);
        end
        int_req = 1'b0;
        repeat (5) tick();
        chk("busy_after_drop", 32'(busy), 0);
`endif
        repeat (3) tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
